pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline (F/D/E/M/W).
- Drives the stall (enable-inverse) and flush (synchronous clear) inputs of every inter-stage register, including the F/D register.
- Arbitrates, in fixed priority, between:
  - exceptions in M
  - instruction/data SRAM wait
  - multi-cycle divide
  - load-use and branch-operand hazards
- Owns the divider start/done sequencing FSM and cycle counter.

Parameters:
- DIV_LAT, 32: cycles the divider needs after div_startE.
- CNT_W, 6: counter width; must satisfy 2^CNT_W > DIV_LAT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- rsD  in  5  D-stage source reg rs
- rtD  in  5  D-stage source reg rt
- branchD  in  1  D-stage branch/jr needs operands now
- writeregE  in  5  E-stage destination reg
- regwriteE  in  1  E-stage writes register file
- memtoregE  in  1  E-stage is a load
- writeregM  in  5  M-stage destination reg
- memtoregM  in  1  M-stage is a load
- divE  in  1  div/divu currently in E
- i_stall  in  1  instruction SRAM not ready
- d_stall  in  1  data SRAM not ready
- exceptM  in  1  exception committed in M
- stallF, stallD, stallE, stallM, stallW  out  1 each  hold PC / stage register
- flushD, flushE, flushM, flushW  out  1 each  clear F/D, D/E, E/M, M/W register
- div_startE  out  1  one-cycle start pulse to divider
- div_doneE  out  1  divider result valid in E
- div_busy  out  1  FSM not IDLE
- exc_redirect  out  1  select exception vector for next PC

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high. At reset, FSM goes to IDLE and counter to 0.
- Output style: all outputs are combinational from state plus inputs.
- Hazard terms:
  - lwstall = memtoregE & writeregE!=0 & (writeregE==rsD | writeregE==rtD).
  - brstall = branchD & match(rsD/rtD) against either
    - (regwriteE & writeregE!=0 & writeregE), or
    - (memtoregM & writeregM!=0 & writeregM).
  - Register 0 never matches.
- Divide FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - divE & !exceptM & !i_stall & !d_stall: div_startE=1, counter<=DIV_LAT-1, go to BUSY.
    - divE but no transition: still assert stallF/D/E, flushM.
  - BUSY:
    - Assert stallF/D/E and flushM.
    - Counter decrements every cycle, even under mem stall.
    - Counter==0: go to DONE.
  - DONE:
    - div_doneE=1; no stall from the divider.
    - divE still high here must NOT restart.
    - Go to IDLE only when !i_stall & !d_stall; otherwise hold DONE with div_doneE held high.
  - Stall length: a divide with no interference holds F/D/E for exactly DIV_LAT+1 cycles.
  - div_busy = (state!=IDLE).
- Priority (highest wins, lower terms masked):
  1. reset
  2. exceptM: flushD/E/M/W=1, exc_redirect=1, all stalls 0. FSM forced to IDLE next cycle; counter cleared.
  3. mem_stall (i_stall|d_stall): stallF/D/E/M/W=1, all flushes 0.
  4. divider (IDLE-with-divE or BUSY): stallF/D/E=1, flushM=1.
  5. lwstall|brstall: stallF=1, stallD=1, flushE=1.
  6. otherwise all 0.
- Exception mid-divide aborts; the divider ignores the stale result because no div_doneE is issued.
- No combinational loop: stall/flush outputs never feed back into hazard inputs inside this block.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - REG_ZERO=5'd0
  - DIV_LAT default
- Sub-module div_seq: holds the FSM and counter.
  - Inputs: clk, reset, divE, hold (mem_stall), abort (exceptM).
  - Outputs: div_startE, div_doneE, div_busy, div_hold.
- Top level contains the hazard comparators and the priority mux.

Test Plan:
- Load-use: memtoregE=1, writeregE=8, rtD=8 for 1 cycle -> stallF=stallD=flushE=1 that cycle; all 0 next cycle once E changes. Repeat with writeregE=0 -> no stall.
- Branch operand: branchD=1, rsD=9, regwriteE=1, writeregE=9 -> stallF/D, flushE=1. Then memtoregM=1, writeregM=9, regwriteE=0 -> still stalled.
- Divide (DIV_LAT=4): divE held high -> div_startE pulses cycle 0; stallF/D/E and flushM high cycles 0-4; div_doneE=1 cycle 5 with stalls 0; no second div_startE.
- Mem stall in DONE: d_stall=1 during DONE for 3 cycles -> all five stalls 1, div_doneE stays 1, FSM stays DONE; IDLE the cycle after d_stall falls.
- Exception mid-divide: exceptM=1 at BUSY cycle 2 -> flushD/E/M/W=1, exc_redirect=1, stalls 0; div_busy=0 next cycle; div_doneE never asserted.
- Reset mid-BUSY: reset=1 one cycle -> div_busy=0 next cycle; with divE=0, all outputs 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         DIV_LAT_DEF = 32;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; slave is the controller side.
interface pipe_hazard_ctrl_if;
  logic [4:0] rsD, rtD, writeregE, writeregM;
  logic       branchD, regwriteE, memtoregE, memtoregM, divE;
  logic       i_stall, d_stall, exceptM;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushD, flushE, flushM, flushW;
  logic       div_startE, div_doneE, div_busy, exc_redirect;

  modport master (
    output rsD, rtD, writeregE, writeregM, branchD, regwriteE, memtoregE,
           memtoregM, divE, i_stall, d_stall, exceptM,
    input  stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW,
           div_startE, div_doneE, div_busy, exc_redirect
  );

  modport slave (
    input  rsD, rtD, writeregE, writeregM, branchD, regwriteE, memtoregE,
           memtoregM, divE, i_stall, d_stall, exceptM,
    output stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW,
           div_startE, div_doneE, div_busy, exc_redirect
  );
endinterface

// File: rtl/pipe_hazard_ctrl_div_seq.sv
// Divider start/done sequencer: IDLE -> BUSY (DIV_LAT cycles) -> DONE.
module div_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic divE,
  input  logic hold,
  input  logic abort,
  output logic div_startE,
  output logic div_doneE,
  output logic div_busy,
  output logic div_hold
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_startE = 1'b0;
    div_doneE  = 1'b0;
    div_hold   = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_hold = divE;
        if (divE && !abort && !hold) begin
          div_startE = 1'b1;
          cnt_d      = CNT_W'(DIV_LAT - 1);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // The divider runs freely, so the count keeps moving under a mem stall.
        div_hold = 1'b1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE: begin
        div_doneE = 1'b1;
        if (!hold) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign div_busy = (state_q != IDLE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: hazard detection plus fixed-priority arbitration.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 6
) (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   hz
);

  logic mem_stall, lwstall, brstall, div_hold, start_raw, done_raw;

  assign mem_stall = hz.i_stall | hz.d_stall;

  assign lwstall = hz.memtoregE &
                   (reg_hit(hz.writeregE, hz.rsD) | reg_hit(hz.writeregE, hz.rtD));

  assign brstall = hz.branchD & (
      (hz.regwriteE & (reg_hit(hz.writeregE, hz.rsD) | reg_hit(hz.writeregE, hz.rtD))) |
      (hz.memtoregM & (reg_hit(hz.writeregM, hz.rsD) | reg_hit(hz.writeregM, hz.rtD))));

  div_seq #(.DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_div_seq (
    .clk        (clk),
    .reset      (reset),
    .divE       (hz.divE),
    .hold       (mem_stall),
    .abort      (hz.exceptM),
    .div_startE (start_raw),
    .div_doneE  (done_raw),
    .div_busy   (hz.div_busy),
    .div_hold   (div_hold)
  );

  always_comb begin
    hz.stallF       = 1'b0;
    hz.stallD       = 1'b0;
    hz.stallE       = 1'b0;
    hz.stallM       = 1'b0;
    hz.stallW       = 1'b0;
    hz.flushD       = 1'b0;
    hz.flushE       = 1'b0;
    hz.flushM       = 1'b0;
    hz.flushW       = 1'b0;
    hz.exc_redirect = 1'b0;
    hz.div_startE   = start_raw & ~reset;
    hz.div_doneE    = done_raw & ~reset;
    if (reset) begin
      // everything quiet while reset is held
    end else if (hz.exceptM) begin
      hz.flushD       = 1'b1;
      hz.flushE       = 1'b1;
      hz.flushM       = 1'b1;
      hz.flushW       = 1'b1;
      hz.exc_redirect = 1'b1;
    end else if (mem_stall) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.stallM = 1'b1;
      hz.stallW = 1'b1;
    end else if (div_hold) begin
      // Hold the divide in E; M receives a bubble each cycle.
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.flushM = 1'b1;
    end else if (lwstall | brstall) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.flushE = 1'b1;
    end
  end

endmodule
